dram_port_arbiter: RTL and testbench

Parametrised multi-channel front end for the single-port data memory (dRam). It lets `N_CH` processor cores share one memory port, where the previous generation tied a single processor directly to dRam. Each cycle it accepts at most one request, using round-robin or fixed-priority arbitration. It registers the accepted command onto the dRam port and routes read data back to the requesting channel after a configurable memory read latency.

---
 rtl/dram_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_dram_port_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter
//   Lets N_CH processor cores share the single port of the data memory (dRam).
//   Each cycle at most one request is accepted, chosen by round-robin
//   (ARB_MODE=0) or fixed priority with channel 0 highest (ARB_MODE=1). The
//   accepted command is registered onto the dRam port. Read data is routed
//   back to the channel that issued the read, RD_LAT+1 cycles after the
//   command appears on the port.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ch_req / ch_we      per-channel request and write(1)/read(0) qualifier
//   ch_addr / ch_wdata  packed per-channel address / write data (channel k at slice k)
//   ch_gnt              combinational one-hot grant
//   ch_rvalid           registered one-cycle read-return pulse, one bit per channel
//   ch_rdata            registered read data shared by all channels
//   mem_addr/mem_wdata  registered dRam address / write data
//   mem_ctrl            registered dRam control: 00 idle, 01 read, 10 write
//   mem_rdata           dRam read data, valid RD_LAT cycles after mem_ctrl=01
//   busy                a command is on the port or a read is in flight
//
// Handshake: a channel raises ch_req and holds it, together with ch_we,
// ch_addr and ch_wdata, until it sees ch_gnt. The request is accepted at the
// rising edge where ch_req[k] & ch_gnt[k] = 1; keeping ch_req high after that
// edge is a new request. Dropping ch_req before a grant withdraws it.
module dram_port_arbiter #(
  parameter int N_CH     = 4,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int ARB_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        ch_req,
  input  logic [N_CH-1:0]        ch_we,
  input  logic [N_CH*ADDR_W-1:0] ch_addr,
  input  logic [N_CH*DATA_W-1:0] ch_wdata,
  output logic [N_CH-1:0]        ch_gnt,
  output logic [N_CH-1:0]        ch_rvalid,
  output logic [DATA_W-1:0]      ch_rdata,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic [1:0]             mem_ctrl,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   busy
);

  localparam int ID_W  = $clog2(N_CH);
  // Stage 0 is loaded at acceptance; the tail is visible in the same cycle
  // as the matching mem_rdata.
  localparam int DEPTH = RD_LAT + 1;

  localparam logic [1:0] CTRL_IDLE = 2'b00;
  localparam logic [1:0] CTRL_RD   = 2'b01;
  localparam logic [1:0] CTRL_WR   = 2'b10;

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_nxt;
  logic [ID_W-1:0]   win_id;
  logic              accept;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [DEPTH-1:0]  rd_vld;
  logic [ID_W-1:0]   rd_id [DEPTH];
  logic [N_CH-1:0]   rvalid_nxt;

  // Arbitration. Both loops scan from the lowest-priority candidate towards
  // the highest so that the last hit is the winner.
  always_comb begin : arbiter
    int idx;
    win_id = '0;
    idx    = 0;
    if (ARB_MODE == 1) begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (ch_req[i]) win_id = ID_W'(i);
      end
    end else begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        idx = int'(ptr) + i;
        if (idx >= N_CH) idx = idx - N_CH;
        if (ch_req[idx]) win_id = ID_W'(idx);
      end
    end
    accept = |ch_req;
    ch_gnt = '0;
    if (accept) ch_gnt[win_id] = 1'b1;
  end

  always_comb begin : winner_mux
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_gnt[i]) begin
        win_we    = ch_we[i];
        win_addr  = ch_addr[i*ADDR_W +: ADDR_W];
        win_wdata = ch_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_nxt = (win_id == ID_W'(N_CH - 1)) ? '0 : win_id + ID_W'(1);

  // Command register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ctrl  <= CTRL_IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ptr       <= '0;
    end else if (accept) begin
      mem_ctrl  <= win_we ? CTRL_WR : CTRL_RD;
      mem_addr  <= win_addr;
      mem_wdata <= win_wdata;
      if (ARB_MODE == 0) ptr <= ptr_nxt;
    end else begin
      mem_ctrl  <= CTRL_IDLE;
    end
  end

  // Read tracking pipeline: {valid, channel id} per issued read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld <= '0;
      for (int i = 0; i < DEPTH; i++) rd_id[i] <= '0;
    end else begin
      rd_vld   <= {rd_vld[DEPTH-2:0], accept & ~win_we};
      rd_id[0] <= win_id;
      for (int i = 1; i < DEPTH; i++) rd_id[i] <= rd_id[i-1];
    end
  end

  always_comb begin
    rvalid_nxt = '0;
    if (rd_vld[DEPTH-1]) rvalid_nxt[rd_id[DEPTH-1]] = 1'b1;
  end

  // Read return. ch_rdata holds its last value between returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_rvalid <= '0;
      ch_rdata  <= '0;
    end else begin
      ch_rvalid <= rvalid_nxt;
      if (rd_vld[DEPTH-1]) ch_rdata <= mem_rdata;
    end
  end

  assign busy = (mem_ctrl != CTRL_IDLE) | (|rd_vld);

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Testbench for dram_port_arbiter.
//   Instance a: N_CH=4, RD_LAT=1, round-robin, backed by a byte-array dRam model.
//   Instance b: N_CH=4, RD_LAT=3, fixed priority, backed by a model whose read
//   data is addr[7:0]^8'h5A delayed by three cycles.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge (registered outputs) or 1 ns after driving (combinational grant).
module tb_dram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam int CW = 32 + 2 + AW + DW;  // {cycle, ctrl, addr, wdata}
  localparam int RW = 32 + 8 + DW;       // {cycle, channel, data}

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic [31:0] cyc = '0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instance a ----------------
  logic            a_rst_n;
  logic [N-1:0]    a_req, a_we, a_gnt, a_rvalid;
  logic [AW-1:0]   a_addr [N];
  logic [DW-1:0]   a_wd   [N];
  logic [N*AW-1:0] a_addr_p;
  logic [N*DW-1:0] a_wd_p;
  logic [DW-1:0]   a_rdata, a_mem_wdata, a_mem_rdata;
  logic [AW-1:0]   a_mem_addr;
  logic [1:0]      a_mem_ctrl;
  logic            a_busy;

  always_comb begin
    a_addr_p = '0;
    a_wd_p   = '0;
    for (int k = 0; k < N; k++) begin
      a_addr_p[k*AW +: AW] = a_addr[k];
      a_wd_p[k*DW +: DW]   = a_wd[k];
    end
  end

  dram_port_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .ARB_MODE(0)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .ch_req(a_req), .ch_we(a_we), .ch_addr(a_addr_p),
    .ch_wdata(a_wd_p), .ch_gnt(a_gnt), .ch_rvalid(a_rvalid), .ch_rdata(a_rdata),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_ctrl(a_mem_ctrl),
    .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  // dRam model, read latency 1
  logic [DW-1:0] a_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (a_mem_ctrl == 2'b10) a_mem[a_mem_addr] <= a_mem_wdata;
    if (a_mem_ctrl == 2'b01) a_mem_rdata <= a_mem[a_mem_addr];
  end

  // ---------------- instance b ----------------
  logic            b_rst_n;
  logic [N-1:0]    b_req, b_we, b_gnt, b_rvalid;
  logic [AW-1:0]   b_addr [N];
  logic [DW-1:0]   b_wd   [N];
  logic [N*AW-1:0] b_addr_p;
  logic [N*DW-1:0] b_wd_p;
  logic [DW-1:0]   b_rdata, b_mem_wdata, b_mem_rdata;
  logic [AW-1:0]   b_mem_addr;
  logic [1:0]      b_mem_ctrl;
  logic            b_busy;
  logic [DW-1:0]   b_pipe [3];

  always_comb begin
    b_addr_p = '0;
    b_wd_p   = '0;
    for (int k = 0; k < N; k++) begin
      b_addr_p[k*AW +: AW] = b_addr[k];
      b_wd_p[k*DW +: DW]   = b_wd[k];
    end
  end

  dram_port_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .ARB_MODE(1)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .ch_req(b_req), .ch_we(b_we), .ch_addr(b_addr_p),
    .ch_wdata(b_wd_p), .ch_gnt(b_gnt), .ch_rvalid(b_rvalid), .ch_rdata(b_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_ctrl(b_mem_ctrl),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  always @(posedge clk) begin
    b_pipe[0] <= (b_mem_ctrl == 2'b01) ? (b_mem_addr[7:0] ^ 8'h5A) : 8'h00;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_mem_rdata = b_pipe[2];

  // ---------------- scoreboard ----------------
  logic [CW-1:0] a_cmd_q [$];
  logic [RW-1:0] a_rsp_q [$];
  logic [RW-1:0] b_rsp_q [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic report_unexpected(input string name, input logic [63:0] got);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h expected nothing (t=%0t)", name, got, $time);
  endtask

  // Command monitor for instance a: every non-idle mem_ctrl must match the
  // head of the queue, including the cycle it appears in.
  logic [CW-1:0] a_cmd_e;
  always @(negedge clk) begin
    if (a_rst_n) begin
      if (a_mem_ctrl != 2'b00) begin
        if (a_cmd_q.size() == 0) report_unexpected("a_cmd_extra", {a_mem_ctrl, a_mem_addr, a_mem_wdata});
        else begin
          a_cmd_e = a_cmd_q.pop_front();
          check("a_cmd", {cyc, a_mem_ctrl, a_mem_addr, a_mem_wdata}, a_cmd_e);
        end
      end else if (a_cmd_q.size() > 0 && a_cmd_q[0][CW-1 -: 32] <= cyc) begin
        a_cmd_e = a_cmd_q.pop_front();
        check("a_cmd_missing", {cyc, a_mem_ctrl, a_mem_addr, a_mem_wdata}, a_cmd_e);
      end
    end
  end

  // Response monitors: every ch_rvalid pulse must match the queue head.
  logic [RW-1:0] a_rsp_e, b_rsp_e;
  logic [7:0]    a_idx, b_idx;
  always @(negedge clk) begin
    if (a_rst_n) begin
      if (|a_rvalid) begin
        a_idx = '0;
        for (int i = 0; i < N; i++) if (a_rvalid[i]) a_idx = 8'(i);
        check("a_rvalid_onehot", 64'($onehot(a_rvalid)), 64'd1);
        if (a_rsp_q.size() == 0) report_unexpected("a_rsp_extra", {a_idx, a_rdata});
        else begin
          a_rsp_e = a_rsp_q.pop_front();
          check("a_rsp", {cyc, a_idx, a_rdata}, a_rsp_e);
        end
      end else if (a_rsp_q.size() > 0 && a_rsp_q[0][RW-1 -: 32] <= cyc) begin
        a_rsp_e = a_rsp_q.pop_front();
        check("a_rsp_missing", {cyc, 8'h00, a_rdata}, a_rsp_e);
      end
    end
  end

  always @(negedge clk) begin
    if (b_rst_n) begin
      if (|b_rvalid) begin
        b_idx = '0;
        for (int i = 0; i < N; i++) if (b_rvalid[i]) b_idx = 8'(i);
        if (b_rsp_q.size() == 0) report_unexpected("b_rsp_extra", {b_idx, b_rdata});
        else begin
          b_rsp_e = b_rsp_q.pop_front();
          check("b_rsp", {cyc, b_idx, b_rdata}, b_rsp_e);
        end
      end else if (b_rsp_q.size() > 0 && b_rsp_q[0][RW-1 -: 32] <= cyc) begin
        b_rsp_e = b_rsp_q.pop_front();
        check("b_rsp_missing", {cyc, 8'h00, b_rdata}, b_rsp_e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called on a falling edge: present requests for one cycle, check the
  // grant, queue the expected command/response, move to the next falling edge.
  task automatic a_step(input logic [N-1:0] req, input logic [N-1:0] exp_gnt,
                        input logic [DW-1:0] exp_rd);
    int k;
    a_req = req;
    #1;
    check("a_gnt", a_gnt, exp_gnt);
    k = -1;
    for (int i = 0; i < N; i++) if (exp_gnt[i]) k = i;
    if (k >= 0) begin
      a_cmd_q.push_back({cyc + 32'd1, (a_we[k] ? 2'b10 : 2'b01), a_addr[k], a_wd[k]});
      if (!a_we[k]) a_rsp_q.push_back({cyc + 32'd3, 8'(k), exp_rd});
    end
    @(negedge clk);
  endtask

  task automatic b_step(input logic [N-1:0] req, input logic [N-1:0] exp_gnt,
                        input logic [DW-1:0] exp_rd, input bit rsp_en);
    int k;
    b_req = req;
    #1;
    check("b_gnt", b_gnt, exp_gnt);
    k = -1;
    for (int i = 0; i < N; i++) if (exp_gnt[i]) k = i;
    if (k >= 0 && rsp_en) b_rsp_q.push_back({cyc + 32'd5, 8'(k), exp_rd});
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_req = '0; a_we = '0; b_req = '0; b_we = '0;
    for (int k = 0; k < N; k++) begin
      a_addr[k] = '0; a_wd[k] = '0; b_addr[k] = '0; b_wd[k] = '0;
    end
    a_mem[19'h00010] = 8'hA5;
    a_mem[19'h00100] = 8'h11;
    a_mem[19'h00101] = 8'h22;
    a_mem[19'h00102] = 8'h33;
    a_mem[19'h00103] = 8'h44;
    a_mem[19'h7FFFF] = 8'h00;
    a_mem[19'h55555] = 8'h00;

    repeat (2) @(negedge clk);
    #1;
    check("a_rst_ctrl", a_mem_ctrl, 2'b00);
    check("a_rst_addr", a_mem_addr, '0);
    check("a_rst_busy", a_busy, 1'b0);
    check("a_rst_rvalid", a_rvalid, '0);
    check("a_rst_rdata", a_rdata, '0);
    check("b_rst_ctrl", b_mem_ctrl, 2'b00);
    @(negedge clk);
    a_rst_n = 1'b1; b_rst_n = 1'b1;

    // Single-channel read: ch1 reads 0x00010 -> 0xA5 three cycles later.
    a_addr[1] = 19'h00010; a_we[1] = 1'b0; a_wd[1] = 8'h00;
    a_step(4'b0010, 4'b0010, 8'hA5);
    a_req = '0;
    #1 check("a_busy_c1", a_busy, 1'b1);
    @(negedge clk);
    #1 check("a_busy_c2", a_busy, 1'b1);
    @(negedge clk);
    #1 check("a_busy_c3", a_busy, 1'b0);
    repeat (2) @(negedge clk);

    // Round-robin from reset with all channels requesting (ptr was 2).
    a_rst_n = 1'b0;
    a_addr[0] = 19'h00100; a_we[0] = 1'b0; a_wd[0] = 8'h00;
    a_addr[1] = 19'h00101; a_we[1] = 1'b0; a_wd[1] = 8'h00;
    a_addr[2] = 19'h00200; a_we[2] = 1'b1; a_wd[2] = 8'hC2;
    a_addr[3] = 19'h00103; a_we[3] = 1'b0; a_wd[3] = 8'h00;
    a_req = 4'b1111;
    #1 check("a_gnt_in_reset", a_gnt, 4'b0001);
    @(negedge clk);
    check("a_no_accept_in_reset", a_mem_ctrl, 2'b00);
    a_rst_n = 1'b1;
    a_step(4'b1111, 4'b0001, 8'h11);
    a_step(4'b1111, 4'b0010, 8'h22);
    a_step(4'b1111, 4'b0100, 8'h00);
    a_step(4'b1111, 4'b1000, 8'h44);
    a_step(4'b1111, 4'b0001, 8'h11);
    a_step(4'b1111, 4'b0010, 8'h22);
    a_req = '0;
    repeat (4) @(negedge clk);

    // ch2 read moves ptr to 3.
    a_addr[2] = 19'h00102; a_we[2] = 1'b0;
    a_step(4'b0100, 4'b0100, 8'h33);

    // Write-then-read: ch3 writes 0x3C to 0x7FFFF, ch0 reads it back.
    a_addr[3] = 19'h7FFFF; a_we[3] = 1'b1; a_wd[3] = 8'h3C;
    a_addr[0] = 19'h7FFFF; a_we[0] = 1'b0; a_wd[0] = 8'h00;
    a_step(4'b1001, 4'b1000, 8'h00);
    a_step(4'b0001, 4'b0001, 8'h3C);
    // ch3 reads the same word (ptr 1 -> wraps to ch3), ptr becomes 0.
    a_we[3] = 1'b0;
    a_step(4'b1000, 4'b1000, 8'h3C);

    // Withdrawn request: ch1 asks for one cycle while ch0 wins, then drops.
    a_addr[0] = 19'h55555; a_we[0] = 1'b1; a_wd[0] = 8'h77;
    a_addr[1] = 19'h00010; a_we[1] = 1'b0; a_wd[1] = 8'h00;
    a_step(4'b0011, 4'b0001, 8'h00);
    a_step(4'b0000, 4'b0000, 8'h00);
    #1 check("a_withdraw_idle", a_mem_ctrl, 2'b00);
    // ch1 now reads back what ch0 wrote.
    a_addr[1] = 19'h55555;
    a_step(4'b0010, 4'b0010, 8'h77);
    a_req = '0;
    repeat (5) @(negedge clk);

    // Fixed priority on b: ch0 (writes) and ch2 (read) for 3 cycles, then ch0 drops.
    b_addr[0] = 19'h00020; b_we[0] = 1'b1; b_wd[0] = 8'h99;
    b_addr[2] = 19'h00033; b_we[2] = 1'b0; b_wd[2] = 8'h00;
    b_step(4'b0101, 4'b0001, 8'h00, 1'b0);
    #1 check("b_ctrl_wr", b_mem_ctrl, 2'b10);
    b_step(4'b0101, 4'b0001, 8'h00, 1'b0);
    b_step(4'b0101, 4'b0001, 8'h00, 1'b0);
    b_step(4'b0100, 4'b0100, 8'h69, 1'b1);
    b_req = '0;
    #1;
    check("b_ctrl_rd", b_mem_ctrl, 2'b01);
    check("b_addr_rd", b_mem_addr, 19'h00033);
    repeat (6) @(negedge clk);
    #1 check("b_rdata_hold", b_rdata, 8'h69);

    // Reset mid-read on b (RD_LAT=3).
    @(negedge clk);
    b_addr[2] = 19'h00044;
    b_step(4'b0100, 4'b0100, 8'h00, 1'b0);
    b_req = '0;
    #1;
    check("b_mid_ctrl", b_mem_ctrl, 2'b01);
    check("b_mid_busy", b_busy, 1'b1);
    b_rst_n = 1'b0;
    #1;
    check("b_rst_ctrl_now", b_mem_ctrl, 2'b00);
    check("b_rst_busy_now", b_busy, 1'b0);
    check("b_rst_rvalid_now", b_rvalid, '0);
    check("b_rst_rdata_now", b_rdata, '0);
    @(negedge clk);
    b_rst_n = 1'b1;
    b_step(4'b1111, 4'b0001, 8'h00, 1'b0);
    b_req = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1 check("b_no_stale_rvalid", b_rvalid, '0);
    end

    check("a_cmd_q_drained", a_cmd_q.size(), 0);
    check("a_rsp_q_drained", a_rsp_q.size(), 0);
    check("b_rsp_q_drained", b_rsp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
